// File: rtl/timer_counter_pkg.sv
// Shared definitions for timer_counter: FSM encoding, register map, CTRL fields.
// TC_AUTO_RELOAD_EN enables Mode 01 (auto-reload); otherwise Mode is forced to 00 on write.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Value actually stored in CTRL[3:0] for a CPU write.
  function automatic logic [3:0] ctrl_wr_filter(input logic [3:0] d);
`ifdef TC_AUTO_RELOAD_EN
    return d;
`else
    return {d[CTRL_IM], MODE_ONESHOT, d[CTRL_EN]};
`endif
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter timer with CTRL/PRESET/COUNT registers and masked IRQ.
// Build option TC_AUTO_RELOAD_EN adds the Mode 01 periodic auto-reload behaviour.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e        state, state_nxt;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count, count_nxt;
  logic             irq_pend;
  logic             ctrl_wr, preset_wr, auto_reload;
  logic             hw_en_clr, pend_set, pend_clr;
  logic             unused_din;

  assign ctrl_wr    = WE && (Addr == ADDR_CTRL);
  assign preset_wr  = WE && (Addr == ADDR_PRESET);
  assign unused_din = ^Din;

`ifdef TC_AUTO_RELOAD_EN
  assign auto_reload = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
`else
  assign auto_reload = 1'b0;
`endif

  // Transitions look only at the registered (pre-write) Enable.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    hw_en_clr = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      S_IDLE: if (ctrl[CTRL_EN]) state_nxt = S_LOAD;
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!ctrl[CTRL_EN]) begin
          state_nxt = S_IDLE;
        end else if (count == '0) begin
          state_nxt = S_INT;
          pend_set  = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
      S_INT: begin
        if (auto_reload) begin
          state_nxt = S_LOAD;
          pend_clr  = 1'b1;
        end else begin
          state_nxt = S_IDLE;
          hw_en_clr = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A CPU CTRL write wins over the hardware Enable clear.
      if (ctrl_wr)        ctrl          <= ctrl_wr_filter(Din[3:0]);
      else if (hw_en_clr) ctrl[CTRL_EN] <= 1'b0;
      if (preset_wr) preset <= Din[WIDTH-1:0];
      if (pend_set)                  irq_pend <= 1'b1;
      else if (ctrl_wr || pend_clr)  irq_pend <= 1'b0;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = {28'b0, ctrl};
      ADDR_PRESET: Dout = 32'(preset);
      ADDR_COUNT:  Dout = 32'(count);
      default:     Dout = '0;
    endcase
  end

  assign IRQ = ctrl[CTRL_IM] & irq_pend;

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter: WIDTH, 32, width of the PRESET and COUNT registers.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Addr  input  2  register select, word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-005 WE  input  1  write strobe for the register at Addr.
REQ-006 Din  input  32  write data.
REQ-007 Dout  output  32  combinational read of the register at Addr.
REQ-008 IRQ  output  1  interrupt request, wired to one HWInt bit of the coprocessor-0 block.

Function
REQ-009 CTRL layout SHALL be: [0] Enable, [2:1] Mode (00 one-shot, 01 auto-reload), [3] IM (IRQ mask), [31:4] read as 0.
REQ-010 Dout SHALL return {28'b0, CTRL[3:0]}, PRESET or COUNT for Addr 0, 1 or 2, and 0 for Addr 3.
REQ-011 A write with WE=1 SHALL update CTRL[3:0] (Addr 0) or PRESET (Addr 1) at the clock edge; writes to Addr 2 or 3 SHALL be ignored.
REQ-012 The FSM SHALL have four states: IDLE, LOAD, CNT and INT.
REQ-013 IDLE: if Enable=1, the FSM SHALL go to LOAD.
REQ-014 LOAD: COUNT SHALL be loaded with PRESET, then the FSM SHALL go to CNT.
REQ-015 CNT: if Enable=0, the FSM SHALL go to IDLE and COUNT SHALL hold its value.
REQ-016 CNT with Enable=1: if COUNT!=0, COUNT SHALL decrement by 1; if COUNT==0, the FSM SHALL go to INT.
REQ-017 PRESET=0 SHALL produce INT on the first CNT cycle; COUNT SHALL never wrap below 0.
REQ-018 INT, Mode 00: Enable SHALL clear and the FSM SHALL go to IDLE.
REQ-019 INT, Mode 01: the FSM SHALL go to LOAD, giving a period of PRESET+3 cycles.
REQ-020 Mode 10 and 11 SHALL behave as Mode 00.
REQ-021 irq_pend SHALL be set on the edge entering INT, and cleared by any CTRL write or on leaving INT in Mode 01.
REQ-022 IRQ SHALL equal IM AND irq_pend.
REQ-023 On a same-cycle conflict, a CPU CTRL write SHALL take priority over the hardware Enable clear in INT.
REQ-024 FSM transitions in a given cycle SHALL use the pre-write Enable.
REQ-025 A PRESET write during CNT SHALL not affect COUNT until the next LOAD.
REQ-026 A CTRL write that clears Enable during LOAD or CNT SHALL stop the count within one cycle (FSM to IDLE by the next CNT evaluation).

Reset
REQ-027 On reset=1 at a clock edge: CTRL, PRESET, COUNT and irq_pend SHALL be 0 and the FSM SHALL be in IDLE.
REQ-028 Reset SHALL override WE in the same cycle.
REQ-029 After reset, IRQ SHALL be 0 and Dout SHALL read 0 for every Addr.
REQ-030 Reset mid-count SHALL abort the count with no IRQ.

Configuration
REQ-031 Macro TC_AUTO_RELOAD_EN: when defined, Mode 01 SHALL behave as in REQ-019.
REQ-032 When TC_AUTO_RELOAD_EN is undefined, Mode[2:1] SHALL be forced to 00 on write (read back 0) and only one-shot behaviour SHALL exist.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, register offsets (CTRL, PRESET, COUNT), CTRL bit positions and Mode codes.
REQ-034 The block SHALL be a single module with no sub-module; the compare/decrement logic stays inline.

Verification
REQ-035 Reset, then read Addr 0..3 -> all 0; IRQ=0.
REQ-036 PRESET=5, CTRL=0x9 (one-shot, IM=1) -> COUNT reads 5,4,3,2,1,0; IRQ rises 8 edges after the CTRL write edge; CTRL reads 0x8; IRQ stays high until a CTRL write, which drops it next cycle.
REQ-037 With TC_AUTO_RELOAD_EN: PRESET=3, CTRL=0xB -> IRQ single-cycle pulses every 6 cycles; COUNT reloads to 3 after each pulse.
REQ-038 PRESET=0, CTRL=0x9 -> IRQ rises 3 edges after the CTRL write.
REQ-039 Mid-count CTRL=0x8 at COUNT=2 -> COUNT freezes at 1 or 2 and no IRQ; CTRL=0x9 then reloads PRESET.
REQ-040 CTRL=0x1 (IM=0) one-shot to completion -> IRQ stays 0; a later write CTRL=0x8 clears irq_pend, so IRQ remains 0.
